ysyx_22050854_ifu: RTL

Instruction fetch unit: the producer side of the decode stage.
- Holds the PC and issues single-beat fetch requests to instruction memory.
- Buffers returned 32-bit instructions in a small FIFO and presents {instr, pc} to decode under a valid/ready handshake.
- Accepts redirects (branch/jump targets) from execute and discards stale in-flight data.

---
 rtl/ysyx_22050854_ifu_pkg.sv | 35 +++
 rtl/ysyx_22050854_ifu_fifo.sv | 76 +++++++
 rtl/ysyx_22050854_ifu.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050854_ifu_pkg.sv
// ysyx_22050854_ifu_pkg
// Shared constants and types for the instruction fetch unit.
//   - XLEN / ILEN            : address and instruction widths
//   - DEFAULT_RESET_PC       : default first fetch address
//   - INSTR_EBREAK           : encoding that stops fetch when
//                              YSYX_22050854_IFU_EBREAK_STOP_EN is defined
//   - S_* state constants    : fetch FSM encoding
//   - ifu_entry_t            : instruction buffer entry {instr, pc}
//   - select_word()          : picks the 32-bit word out of a doubleword
package ysyx_22050854_ifu_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h8000_0000;
    localparam logic [ILEN-1:0] INSTR_EBREAK     = 32'h0010_0073;

    typedef logic [1:0] ifu_state_t;

    localparam ifu_state_t S_IDLE = 2'd0;
    localparam ifu_state_t S_REQ  = 2'd1;
    localparam ifu_state_t S_WAIT = 2'd2;
    localparam ifu_state_t S_HALT = 2'd3;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } ifu_entry_t;

    function automatic logic [ILEN-1:0] select_word(input logic [XLEN-1:0] data,
                                                    input logic            upper);
        return upper ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/ysyx_22050854_ifu_fifo.sv
// ysyx_22050854_ifu_fifo
// Instruction buffer: power-of-two deep FIFO of {instr, pc} entries.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : drop the head entry
//   flush      : empty the FIFO; wins over a simultaneous push/pop
//   count      : number of valid entries
//   head       : entry at the head (meaningful when count != 0)
// The caller guarantees no push when full and no pop when empty.
module ysyx_22050854_ifu_fifo
    import ysyx_22050854_ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  ifu_entry_t                 push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output ifu_entry_t                 head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    ifu_entry_t       mem_q [DEPTH];
    ifu_entry_t       mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ysyx_22050854_ifu.sv
// ysyx_22050854_ifu
// Instruction fetch unit: keeps the PC, issues single-beat fetches,
// buffers returned words and hands {instr, pc} to decode.
// Optional feature macro: YSYX_22050854_IFU_EBREAK_STOP_EN
//   (stop fetching after an ebreak is buffered; otherwise halted is 0).
// Ports:
//   clk, rst                           : clock, synchronous active-high reset
//   mem_req_valid/ready, mem_req_addr  : fetch request (8-byte aligned)
//   mem_resp_valid, mem_resp_data      : fetch response (always accepted)
//   out_valid/ready, out_instr, out_pc : instruction to decode
//   redirect_valid, redirect_pc        : execute redirect
//   halted                             : fetch stopped on ebreak
//
// state  | meaning
// IDLE   | no request pending, waiting for buffer space
// REQ    | request presented, waiting for mem_req_ready
// WAIT   | one request outstanding, waiting for the response
// HALT   | ebreak buffered, fetch stopped until redirect/reset
module ysyx_22050854_ifu
    import ysyx_22050854_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        halted
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_t        state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic              drop_q, drop_d;

    logic              resp_take;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic [ILEN-1:0]   resp_word;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     count_nxt;
    logic              space_nxt;
    ifu_entry_t        head;
    ifu_entry_t        push_data;
    logic              unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign resp_take = (state_q == S_WAIT) && mem_resp_valid;
    assign req_fire  = (state_q == S_REQ) && mem_req_ready;
    assign resp_word = select_word(mem_resp_data, req_pc_q[2]);
    assign push_data = '{instr: resp_word, pc: req_pc_q};

    // Redirect flushes the buffer, so neither a push nor a pop matters then.
    assign push = resp_take && !drop_q && !redirect_valid;
    assign pop  = out_valid && out_ready && !redirect_valid;

    // Occupancy after this cycle; WAIT has just retired its request, so
    // this alone decides whether another request may be issued.
    assign count_nxt = redirect_valid ? '0 : (fifo_count + CW'(push) - CW'(pop));
    assign space_nxt = count_nxt < CW'(FIFO_DEPTH);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;

        case (state_q)
            S_IDLE: begin
                if (space_nxt) state_d = S_REQ;
            end
            S_REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 64'd4;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp_take) begin
                    drop_d  = 1'b0;
                    state_d = space_nxt ? S_REQ : S_IDLE;
`ifdef YSYX_22050854_IFU_EBREAK_STOP_EN
                    if (push && (resp_word == INSTR_EBREAK)) state_d = S_HALT;
`endif
                end
            end
            S_HALT: begin
`ifdef YSYX_22050854_IFU_EBREAK_STOP_EN
                state_d = S_HALT;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect_valid) begin
            pc_d = {redirect_pc[63:2], 2'b00};
            case (state_q)
                S_REQ: begin
                    // An accepted request is now in flight for a stale pc.
                    if (req_fire) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (!resp_take) drop_d = 1'b1;
                end
                S_HALT:  state_d = S_REQ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
        end
    end

    ysyx_22050854_ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .head      (head)
    );

    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_addr  = mem_req_valid ? {pc_q[63:3], 3'b000} : '0;
    assign out_valid     = (fifo_count != '0);
    assign out_instr     = out_valid ? head.instr : '0;
    assign out_pc        = out_valid ? head.pc : '0;

`ifdef YSYX_22050854_IFU_EBREAK_STOP_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
